alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute-stage ALU sitting directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU opcode, the operand-B select flag and the register/immediate operands, and produces a registered result.
- Logical/arithmetic/compare ops complete in 1 cycle; shifts run on an iterative 1-bit-per-cycle shifter with a busy handshake, so the PC/writeback logic stalls while a shift is in flight.

Parameters:
- XLEN, 32, datapath width in bits.
- SHAMT_W, 5, shift-amount width; equals log2(XLEN).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  issue strobe; operands and opcode are sampled on the clk edge when in_valid=1 and busy=0.
- ALUop  in  4  operation code; encoding is {func7 bit, func3}.
- ALUdata_flag  in  1  1 selects rs2_data as operand B; 0 selects imm.
- rs1_data  in  XLEN  operand A.
- rs2_data  in  XLEN  register operand B.
- imm  in  XLEN  sign-extended immediate operand B.
- busy  out  1  high while an operation is accepted but not yet completed.
- result_valid  out  1  one-cycle pulse when result is updated.
- result  out  XLEN  registered result; holds its value until the next completion.
- lt_flag  out  1  registered result[0] for SLT/SLTU ops, for branch resolve; 0 for other ops.
- zero_flag  out  1  registered (result == 0).

Behaviour:
- Reset (asynchronous, rst=1): busy=0, result_valid=0, result=0, lt_flag=0, zero_flag=0, FSM returns to IDLE. A reset mid-shift aborts the shift and produces no result_valid.
- Operand B is opb = ALUdata_flag ? rs2_data : imm.
- Opcode map:
  - 0000 ADD, 1000 SUB (both modulo 2^XLEN).
  - 0010 SLT (signed), 0011 SLTU (unsigned); result is 0 or 1, zero-extended.
  - 0100 XOR, 0110 OR, 0111 AND.
  - 0001 SLL, 0101 SRL, 1101 SRA.
  - 1111 NOP: result=0 and result_valid is still pulsed.
  - Every other code behaves as NOP.
- Shift amount is opb[SHAMT_W-1:0]; upper bits of opb are ignored.
- FSM states:
  - IDLE:
    - On accept with a non-shift op: compute combinationally, register on the same edge; result_valid=1 in the following cycle; stay in IDLE.
    - On accept with a shift op: load shift register=rs1_data, counter=shamt, latch direction and arithmetic bit, set busy=1, go to SHIFT.
  - SHIFT:
    - Each cycle with counter!=0: shift 1 bit, decrement counter.
    - SLL fills with 0. SRL fills with 0. SRA fills with bit XLEN-1 of the shift register.
    - When counter==0: write the shift register to result, pulse result_valid, clear busy, go to IDLE. The next issue is accepted on that same cycle, because busy is low in that cycle.
- Latency:
  - Non-shift ops: 1 cycle.
  - Shifts: shamt+1 cycles from accept to result_valid. shamt=0 gives 1 cycle with result=rs1_data.
- in_valid asserted while busy=1 is ignored; the issuer must hold it. Operand inputs may change freely after accept.
- zero_flag and lt_flag update only together with result_valid.
- Back-to-back non-shift issues: one result per cycle, no bubble.

Optional Feature:
- Macro: ALU_FAST_SHIFT_EN.
- Defined: shifts use a combinational barrel shifter and complete like non-shift ops (1-cycle latency, busy never asserts, SHIFT state is not synthesised).
- Undefined: iterative shifter as described above.
- Results must be bit-identical in both builds; only latency differs.

Decomposition:
- Shared package/defines file holds:
  - ALUop localparams (ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_NOP).
  - FSM state encodings (S_IDLE, S_SHIFT).
  - XLEN default.
- One natural sub-module: alu_serial_shifter, containing the shift register, counter and done strobe. The top keeps the operand mux, the combinational ops, the FSM and the output registers.

Test Plan:
- Reset mid-shift: issue SLL, shamt=20; assert rst at cycle 5 -> busy=0 and result=0 immediately; no result_valid pulse ever follows.
- ADD/SUB wrap: rs1=0xFFFFFFFF, imm=1, flag=0, ALUop=0000 -> next cycle result=0, zero_flag=1. Then SUB: rs1=0, rs2=1, flag=1 -> result=0xFFFFFFFF.
- SLT vs SLTU: rs1=0xFFFFFFFF, rs2=1, flag=1. ALUop=0010 -> result=1, lt_flag=1. ALUop=0011 -> result=0, lt_flag=0.
- SRA iterative: rs1=0x80000000, imm=4, ALUop=1101 -> busy high for 4 cycles; result_valid 5 cycles after accept; result=0xF8000000. in_valid held during busy is not accepted early.
- Shift boundaries:
  - SLL with shamt=0 -> 1-cycle latency, result=rs1.
  - SRL with imm=0x3F -> shamt=31, rs1=0x80000000 -> result=1 after 32 cycles.
- NOP/back-to-back: ALUop=1111 then AND (0x0F0F0F0F & 0x00FF00FF) on consecutive cycles -> result 0 then 0x000F000F, two consecutive result_valid pulses. Rerun the whole suite with ALU_FAST_SHIFT_EN defined: identical results, all latencies 1.

Source files
------------

// File: rtl/alu_exec_unit_pkg.sv
// alu_exec_unit_pkg
//   Shared definitions for the execute-stage ALU.
//   - XLEN_DEF  : default datapath width
//   - ALU_*     : ALUop encodings ({func7 bit, func3})
//   - state_t   : issue/shift FSM states (S_IDLE, S_SHIFT)
package alu_exec_unit_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_NOP  = 4'b1111;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/alu_exec_unit_serial_shifter.sv
// alu_serial_shifter
//   Iterative 1-bit-per-cycle shifter used by alu_exec_unit.
//   Ports:
//     clk, rst       : clock, async active-high reset
//     load           : capture load_data/load_cnt/direction/arith bits
//     load_data      : value to shift
//     load_cnt       : number of 1-bit shifts to perform
//     load_right     : 1 = right shift, 0 = left shift
//     load_arith     : 1 = right shift fills with the sign bit
//     shift_next     : shift register value after the current cycle's shift
//     done           : the shift taken on this edge is the last one
module alu_serial_shifter
  import alu_exec_unit_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [XLEN-1:0]    load_data,
  input  logic [SHAMT_W-1:0] load_cnt,
  input  logic               load_right,
  input  logic               load_arith,
  output logic [XLEN-1:0]    shift_next,
  output logic               done
);

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  logic [XLEN-1:0]    sreg_r;
  logic [SHAMT_W-1:0] cnt_r;
  logic               right_r;
  logic               arith_r;
  logic               fill_s;

  // One-bit shift of the current register contents in the latched direction.
  always_comb begin
    fill_s = arith_r & sreg_r[XLEN-1];
    if (right_r) begin
      shift_next = {fill_s, sreg_r[XLEN-1:1]};
    end else begin
      shift_next = {sreg_r[XLEN-2:0], 1'b0};
    end
  end

  // Completion is flagged on the edge that performs the final shift, so the
  // owner can register shift_next as the result on that same edge.
  assign done = (cnt_r == CNT_ONE);

  // Shift register, remaining-count and mode bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_r  <= {XLEN{1'b0}};
      cnt_r   <= {SHAMT_W{1'b0}};
      right_r <= 1'b0;
      arith_r <= 1'b0;
    end else if (load) begin
      sreg_r  <= load_data;
      cnt_r   <= load_cnt;
      right_r <= load_right;
      arith_r <= load_arith;
    end else if (cnt_r != {SHAMT_W{1'b0}}) begin
      sreg_r  <= shift_next;
      cnt_r   <= cnt_r - CNT_ONE;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execute-stage ALU with registered result. Single-cycle logic, arithmetic
//   and compare ops; shifts are iterative (1 bit/cycle, busy asserted) unless
//   ALU_FAST_SHIFT_EN is defined, in which case a barrel shifter makes every
//   op single-cycle and busy never asserts.
//   Ports:
//     clk, rst        : clock, async active-high reset
//     in_valid        : issue strobe, accepted when busy=0
//     ALUop           : {func7 bit, func3} operation code
//     ALUdata_flag    : 1 = rs2_data is operand B, 0 = imm
//     rs1_data        : operand A
//     rs2_data, imm   : operand B candidates
//     busy            : shift in flight, issue is held off
//     result_valid    : one-cycle completion pulse
//     result          : registered result, held until next completion
//     lt_flag         : result[0] for SLT/SLTU, else 0
//     zero_flag       : result == 0
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [3:0]      ALUop,
  input  logic            ALUdata_flag,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic            lt_flag,
  output logic            zero_flag
);

  state_t             state_r, state_n_s;
  logic               busy_r, busy_n_s;
  logic               rv_r;
  logic [XLEN-1:0]    result_r, res_n_s;
  logic               lt_r, lt_n_s;
  logic               zero_r;
  logic               done_n_s;
  logic               accept_s;
  logic               is_cmp_s;
  logic [XLEN-1:0]    opb_s;
  logic [SHAMT_W-1:0] shamt_s;
  logic [XLEN-1:0]    comb_res_s;
`ifndef ALU_FAST_SHIFT_EN
  logic               is_shift_s;
  logic               load_s;
  logic [XLEN-1:0]    sh_next_s;
  logic               sh_done_s;
`endif

  assign opb_s    = ALUdata_flag ? rs2_data : imm;
  assign shamt_s  = opb_s[SHAMT_W-1:0];
  assign accept_s = in_valid & ~busy_r;
  assign is_cmp_s = (ALUop == ALU_SLT) | (ALUop == ALU_SLTU);

  // Single-cycle datapath. In the iterative build a shift only takes this
  // path when shamt is zero, where the answer is simply rs1_data.
  always_comb begin
    comb_res_s = {XLEN{1'b0}};
    case (ALUop)
      ALU_ADD:  comb_res_s = rs1_data + opb_s;
      ALU_SUB:  comb_res_s = rs1_data - opb_s;
      ALU_SLT:  comb_res_s = {{(XLEN-1){1'b0}}, ($signed(rs1_data) < $signed(opb_s))};
      ALU_SLTU: comb_res_s = {{(XLEN-1){1'b0}}, (rs1_data < opb_s)};
      ALU_XOR:  comb_res_s = rs1_data ^ opb_s;
      ALU_OR:   comb_res_s = rs1_data | opb_s;
      ALU_AND:  comb_res_s = rs1_data & opb_s;
`ifdef ALU_FAST_SHIFT_EN
      ALU_SLL:  comb_res_s = rs1_data << shamt_s;
      ALU_SRL:  comb_res_s = rs1_data >> shamt_s;
      ALU_SRA:  comb_res_s = XLEN'($signed(rs1_data) >>> shamt_s);
`else
      ALU_SLL:  comb_res_s = rs1_data;
      ALU_SRL:  comb_res_s = rs1_data;
      ALU_SRA:  comb_res_s = rs1_data;
`endif
      ALU_NOP:  comb_res_s = {XLEN{1'b0}};
      default:  comb_res_s = {XLEN{1'b0}};
    endcase
  end

`ifndef ALU_FAST_SHIFT_EN
  assign is_shift_s = (ALUop == ALU_SLL) | (ALUop == ALU_SRL) | (ALUop == ALU_SRA);

  alu_serial_shifter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load       (load_s),
    .load_data  (rs1_data),
    .load_cnt   (shamt_s),
    .load_right (ALUop != ALU_SLL),
    .load_arith (ALUop == ALU_SRA),
    .shift_next (sh_next_s),
    .done       (sh_done_s)
  );
`endif

  // FSM next state and completion/result selection.
  always_comb begin
    state_n_s = state_r;
    busy_n_s  = busy_r;
    res_n_s   = {XLEN{1'b0}};
    lt_n_s    = 1'b0;
    done_n_s  = 1'b0;
`ifndef ALU_FAST_SHIFT_EN
    load_s    = 1'b0;
`endif
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
`ifndef ALU_FAST_SHIFT_EN
          if (is_shift_s && (shamt_s != {SHAMT_W{1'b0}})) begin
            load_s    = 1'b1;
            busy_n_s  = 1'b1;
            state_n_s = S_SHIFT;
          end else begin
            done_n_s  = 1'b1;
            res_n_s   = comb_res_s;
            lt_n_s    = is_cmp_s & comb_res_s[0];
          end
`else
          done_n_s = 1'b1;
          res_n_s  = comb_res_s;
          lt_n_s   = is_cmp_s & comb_res_s[0];
`endif
        end else begin
          state_n_s = S_IDLE;
        end
      end
`ifndef ALU_FAST_SHIFT_EN
      S_SHIFT: begin
        if (sh_done_s) begin
          done_n_s  = 1'b1;
          res_n_s   = sh_next_s;
          busy_n_s  = 1'b0;
          state_n_s = S_IDLE;
        end else begin
          state_n_s = S_SHIFT;
        end
      end
`endif
      default: begin
        state_n_s = S_IDLE;
        busy_n_s  = 1'b0;
      end
    endcase
  end

  // State, busy and output registers; flags move only with a completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      busy_r   <= 1'b0;
      rv_r     <= 1'b0;
      result_r <= {XLEN{1'b0}};
      lt_r     <= 1'b0;
      zero_r   <= 1'b0;
    end else begin
      state_r <= state_n_s;
      busy_r  <= busy_n_s;
      rv_r    <= done_n_s;
      if (done_n_s) begin
        result_r <= res_n_s;
        lt_r     <= lt_n_s;
        zero_r   <= (res_n_s == {XLEN{1'b0}});
      end
    end
  end

  assign busy         = busy_r;
  assign result_valid = rv_r;
  assign result       = result_r;
  assign lt_flag      = lt_r;
  assign zero_flag    = zero_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
//   Scoreboard bench for alu_exec_unit. Expected results and completion
//   cycles are queued at issue and compared on every result_valid pulse.
//   Build with ALU_FAST_SHIFT_EN to exercise the barrel-shifter variant.
module tb_alu_exec_unit;

  typedef struct packed {
    logic [31:0] res;
    logic        lt;
    logic        zero;
    logic [31:0] due;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [3:0]  ALUop;
  logic        ALUdata_flag;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;
  logic        lt_flag;
  logic        zero_flag;

  exp_t sb[$];
  int   n_vec;
  int   n_err;
  int   edge_cnt;
  int   last_wait;

  alu_exec_unit dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .ALUop        (ALUop),
    .ALUdata_flag (ALUdata_flag),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .imm          (imm),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .lt_flag      (lt_flag),
    .zero_flag    (zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0110: return a | b;
      4'b0111: return a & b;
      4'b0001: return a << sh;
      4'b0101: return a >> sh;
      4'b1101: return $unsigned($signed(a) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  // Drive one op from a negedge, hold in_valid until accepted, queue the
  // expectation with the edge index on which result_valid must be visible.
  task automatic issue(input logic [3:0] op, input logic flag, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im,
                       input logic [31:0] exp, input bit push);
    exp_t       e;
    int         tries;
    int         acc;
    logic [4:0] sh;
    ALUop        = op;
    ALUdata_flag = flag;
    rs1_data     = a;
    rs2_data     = b;
    imm          = im;
    in_valid     = 1'b1;
    tries = 0;
    while (busy === 1'b1 && tries < 200) begin
      @(negedge clk);
      tries++;
    end
    last_wait = tries;
    if (tries >= 200) check_val("issue_timeout", 32'(tries), 32'd0);
    acc    = edge_cnt + 1;
    sh     = flag ? b[4:0] : im[4:0];
    e.res  = exp;
    e.lt   = (op == 4'b0010 || op == 4'b0011) ? exp[0] : 1'b0;
    e.zero = (exp == 32'd0);
    e.due  = 32'(acc);
`ifndef ALU_FAST_SHIFT_EN
    if (op == 4'b0001 || op == 4'b0101 || op == 4'b1101) e.due = 32'(acc) + 32'(sh);
`endif
    if (push) sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int tries;
    tries = 0;
    while (sb.size() != 0 && tries < 200) begin
      @(negedge clk);
      tries++;
    end
    check_val("drain", 32'(sb.size()), 32'd0);
  endtask

  // Completion monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("spurious_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_val("result", result, e.res);
        check_val("lt_flag", {31'd0, lt_flag}, {31'd0, e.lt});
        check_val("zero_flag", {31'd0, zero_flag}, {31'd0, e.zero});
        check_val("latency", 32'(edge_cnt), e.due);
      end
    end
  end

  logic [3:0] ops_tbl [0:11];

  initial begin
    logic [31:0] a, b, im, opb;
    logic        fl;
    logic [3:0]  op;
    bit          push_rst;
    n_vec = 0;
    n_err = 0;
    edge_cnt = 0;
    last_wait = 0;
    ops_tbl = '{4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b0100, 4'b0110,
                4'b0111, 4'b0001, 4'b0101, 4'b1101, 4'b1111, 4'b1010};
    rst = 1'b1;
    in_valid = 1'b0;
    ALUop = 4'b0000;
    ALUdata_flag = 1'b0;
    rs1_data = 32'd0;
    rs2_data = 32'd0;
    imm = 32'd0;
    repeat (2) @(negedge clk);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_valid", {31'd0, result_valid}, 32'd0);
    check_val("rst_result", result, 32'd0);
    check_val("rst_lt", {31'd0, lt_flag}, 32'd0);
    check_val("rst_zero", {31'd0, zero_flag}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ADD wrap, SUB wrap, signed vs unsigned compare
    issue(4'b0000, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 32'd1, 32'd0, 1'b1);
    issue(4'b1000, 1'b1, 32'd0, 32'd1, 32'h7777_0000, 32'hFFFF_FFFF, 1'b1);
    issue(4'b0010, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1, 1'b1);
    issue(4'b0011, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b1);

    // SRA iterative, then an op held during busy
    issue(4'b1101, 1'b0, 32'h8000_0000, 32'd0, 32'd4, 32'hF800_0000, 1'b1);
    issue(4'b0100, 1'b1, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'd0, 32'h5A5A_A5A5, 1'b1);
`ifdef ALU_FAST_SHIFT_EN
    check_val("sra_busy_cycles", 32'(last_wait), 32'd0);
`else
    check_val("sra_busy_cycles", 32'(last_wait), 32'd4);
`endif

    // Shift boundaries: shamt 0 (upper opb bits ignored) and shamt 31
    issue(4'b0001, 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFE0, 32'h1234_5678, 1'b1);
    issue(4'b0101, 1'b0, 32'h8000_0000, 32'd0, 32'h0000_003F, 32'd1, 1'b1);

    // NOP then AND back-to-back, then an undefined code
    issue(4'b1111, 1'b1, 32'hDEAD_BEEF, 32'h1, 32'd0, 32'd0, 1'b1);
    issue(4'b0111, 1'b1, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'd0, 32'h000F_000F, 1'b1);
    issue(4'b1010, 1'b1, 32'h1111_1111, 32'h2222_2222, 32'd0, 32'd0, 1'b1);
    issue(4'b0110, 1'b0, 32'h0000_1000, 32'd0, 32'h0000_0001, 32'h0000_1001, 1'b1);

    // Random mix against the reference model
    for (int i = 0; i < 40; i++) begin
      op  = ops_tbl[$urandom_range(0, 11)];
      fl  = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      im  = $urandom;
      opb = fl ? b : im;
      issue(op, fl, a, b, im, model(op, a, opb), 1'b1);
    end
    drain();

    // Reset mid-shift: put a nonzero result in place, then abort an SLL by 20
    issue(4'b0000, 1'b0, 32'h0000_0040, 32'd0, 32'd1, 32'h0000_0041, 1'b1);
    drain();
`ifdef ALU_FAST_SHIFT_EN
    push_rst = 1'b1;
`else
    push_rst = 1'b0;
`endif
    issue(4'b0001, 1'b0, 32'h0000_0003, 32'd0, 32'd20, 32'h0030_0000, push_rst);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_val("abort_result", result, 32'd0);
    check_val("abort_valid", {31'd0, result_valid}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (40) @(negedge clk);
    check_val("abort_idle_busy", {31'd0, busy}, 32'd0);
    check_val("abort_result_held", result, 32'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
